bcd_serial_sum_ctrl: RTL and testbench
======================================

Name: bcd_serial_sum_ctrl

Overview:
- Sequencer that adds two DIGITS-wide packed-BCD operands one digit per clock, least significant digit first.
- Drives an external combinational one-digit BCD adder through its digit ports (dx/dy/dc out, dz/dco in) and assembles the multi-digit result.
- Holds the inter-digit carry in a register, sits between the operand source and the single-digit adder stage, and reports the result with a start/busy/done handshake.

Parameters:
- DIGITS, 4, number of BCD digits per operand (minimum 1).

Ports:
- clk_in  in  1  single clock, rising edge.
- rst_n_in  in  1  asynchronous active-low reset.
- start_in  in  1  request a new sum; sampled only in IDLE.
- a_in  in  4*DIGITS  operand A, packed BCD, digit 0 in bits [3:0].
- b_in  in  4*DIGITS  operand B, packed BCD.
- cin_in  in  1  initial carry into digit 0.
- busy_out  out  1  high while not IDLE.
- done_out  out  1  one-cycle pulse when the result is valid.
- err_out  out  1  operand contained a digit >9; valid with done_out, held until the next accepted start.
- sum_out  out  4*DIGITS  packed-BCD result; held until the next accepted start.
- cout_out  out  1  carry out of the top digit; held like sum_out.
- dx_out  out  4  digit of A to the digit adder.
- dy_out  out  4  digit of B to the digit adder.
- dc_out  out  1  carry to the digit adder.
- dz_in  in  4  digit sum returned by the digit adder (combinational, same cycle).
- dco_in  in  1  digit carry returned by the digit adder.

Behaviour:
- Clock and reset: one clock (clk_in). rst_n_in is asynchronous and active-low.
- Reset value of every register and output is 0; state is IDLE.
- States are IDLE, RUN and DONE.
- IDLE, start_in=1:
  - Latch a_in, b_in and cin_in; clear sum_out, cout_out and err_out; set the digit index to 0.
  - If any digit of a_in or b_in is >9: set err_out=1 and go to DONE (sum_out=0, cout_out=0).
  - Otherwise go to RUN.
- RUN, per cycle at index i (0..DIGITS-1):
  - dx_out = A digit i, dy_out = B digit i, dc_out = carry register.
  - At the clock edge: sum digit i <= dz_in, carry register <= dco_in, i <= i+1.
  - After i = DIGITS-1: cout_out <= dco_in and go to DONE.
- DONE: done_out=1 for this single cycle, then go to IDLE.
- Digit ports outside RUN: dx_out, dy_out and dc_out are 0.
- busy_out = (state != IDLE).
- Latency:
  - Start accepted at edge 0; RUN occupies cycles 1..DIGITS; done_out is high in cycle DIGITS+1.
  - Error path: done_out is high in cycle 1.
- Handshake boundaries:
  - start_in while busy_out=1 is ignored, with no queuing.
  - start_in held high through DONE is first sampled again in the IDLE cycle after DONE, which gives back-to-back operation.
- Operand stability: a_in and b_in may change after acceptance; only the latched copies are used.
- The index counter is clog2(DIGITS) bits wide, or 1 bit when DIGITS=1. The index never wraps inside an operation.
- dz_in and dco_in are trusted. A dz_in >9 returned by the digit adder is captured as-is and does not set err_out.
- Reset asserted mid-RUN aborts immediately:
  - All outputs go to 0.
  - After release the block is in IDLE and needs a new start.

Decomposition:
- Shared package bcd_pkg holds:
  - DIGIT_W = 4 and BCD_MAX = 4'd9.
  - The state enum {IDLE, RUN, DONE}.
  - A function extracting digit i from a packed vector.
- Sub-module bcd_digit_check: combinational, parameter DIGITS, input a packed vector, output 1 when any digit >9. It is instantiated twice, once for A and once for B.
- The digit adder stays outside this block; the bench connects a behavioural model of it to the digit ports.

Test Plan:
- DIGITS=4, a=0x1234, b=0x5678, cin=0 -> sum_out=0x6912, cout_out=0, err_out=0; done_out in cycle 5; busy_out high in cycles 1..5.
- a=0x9999, b=0x0001, cin=0 -> sum_out=0x0000, cout_out=1; the carry ripples through all four RUN cycles (dc_out = 0,1,1,1).
- a=0x0000, b=0x0000, cin=1 -> sum_out=0x0001, cout_out=0; dc_out=1 in the first RUN cycle only.
- a=0x12A4, b=0x0000 -> err_out=1, sum_out=0, done_out in cycle 1, dx/dy/dc stay 0 throughout.
- Start pulsed again in cycle 2 with a=0x1111 -> ignored; the first result is unchanged. Then start held high -> the second operation is accepted in the cycle after DONE.
- rst_n_in low in cycle 3 of a run -> all outputs 0 at once and done_out never pulses; after release, a=0x0500, b=0x0500 -> sum_out=0x1000.

Source files
------------

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared constants, state type and digit helper for the serial BCD adder
package bcd_pkg;

   localparam int          DIGIT_W    = 4;
   localparam logic [3:0]  BCD_MAX    = 4'd9;
   // Widest operand the digit helper can index into
   localparam int          MAX_DIGITS = 32;
   localparam int          VEC_MAX_W  = DIGIT_W * MAX_DIGITS;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Return digit idx of a packed-BCD vector (digit 0 in the low nibble)
   function automatic logic [DIGIT_W-1:0] get_digit(input logic [VEC_MAX_W-1:0] vec,
                                                    input int unsigned          idx);
      return vec[idx*DIGIT_W +: DIGIT_W];
   endfunction

endpackage

// File: rtl/bcd_digit_check.sv
// rtl/bcd_digit_check.sv - flags a packed-BCD vector holding any digit above 9
module bcd_digit_check
   import bcd_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic [DIGIT_W*DIGITS-1:0] vec,
   output logic                      bad
);

   // Any nibble above 9 makes the operand invalid
   always_comb begin
      bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (vec[i*DIGIT_W +: DIGIT_W] > BCD_MAX) begin
            bad = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bcd_serial_sum_ctrl.sv
// rtl/bcd_serial_sum_ctrl.sv - digit-serial packed-BCD adder sequencer around an external digit adder
module bcd_serial_sum_ctrl
   import bcd_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic                      clk_in,
   input  logic                      rst_n_in,
   input  logic                      start_in,
   input  logic [DIGIT_W*DIGITS-1:0] a_in,
   input  logic [DIGIT_W*DIGITS-1:0] b_in,
   input  logic                      cin_in,
   output logic                      busy_out,
   output logic                      done_out,
   output logic                      err_out,
   output logic [DIGIT_W*DIGITS-1:0] sum_out,
   output logic                      cout_out,
   output logic [DIGIT_W-1:0]        dx_out,
   output logic [DIGIT_W-1:0]        dy_out,
   output logic                      dc_out,
   input  logic [DIGIT_W-1:0]        dz_in,
   input  logic                      dco_in
);

   localparam int              VW       = DIGIT_W * DIGITS;
   localparam int              IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

   state_t             state;
   logic [IDX_W-1:0]   idx;
   logic [IDX_W-1:0]   nxt_idx;
   logic [VW-1:0]      a_q;
   logic [VW-1:0]      b_q;
   logic [VW-1:0]      sum_q;
   logic [DIGIT_W-1:0] dx_q;
   logic [DIGIT_W-1:0] dy_q;
   logic               dc_q;
   logic               cout_q;
   logic               err_q;
   logic               done_q;
   logic               busy_q;
   logic               a_bad;
   logic               b_bad;

   bcd_digit_check #(.DIGITS(DIGITS)) u_check_a (.vec(a_in), .bad(a_bad));
   bcd_digit_check #(.DIGITS(DIGITS)) u_check_b (.vec(b_in), .bad(b_bad));

   // Wraps only on the last digit, where it is never used
   assign nxt_idx = idx + 1'b1;

   // Sequencer: dx/dy/dc are preloaded one cycle ahead so the digit ports are registered,
   // and dc_q doubles as the inter-digit carry register
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state  <= IDLE;
         idx    <= '0;
         a_q    <= '0;
         b_q    <= '0;
         sum_q  <= '0;
         dx_q   <= '0;
         dy_q   <= '0;
         dc_q   <= 1'b0;
         cout_q <= 1'b0;
         err_q  <= 1'b0;
         done_q <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done_q <= 1'b0;
               if (start_in) begin
                  a_q    <= a_in;
                  b_q    <= b_in;
                  idx    <= '0;
                  sum_q  <= '0;
                  cout_q <= 1'b0;
                  busy_q <= 1'b1;
                  if (a_bad || b_bad) begin
                     err_q  <= 1'b1;
                     done_q <= 1'b1;
                     state  <= DONE;
                  end else begin
                     err_q  <= 1'b0;
                     dx_q   <= a_in[DIGIT_W-1:0];
                     dy_q   <= b_in[DIGIT_W-1:0];
                     dc_q   <= cin_in;
                     state  <= RUN;
                  end
               end
            end
            RUN: begin
               sum_q[idx*DIGIT_W +: DIGIT_W] <= dz_in;
               if (idx == LAST_IDX) begin
                  cout_q <= dco_in;
                  dx_q   <= '0;
                  dy_q   <= '0;
                  dc_q   <= 1'b0;
                  done_q <= 1'b1;
                  state  <= DONE;
               end else begin
                  idx  <= nxt_idx;
                  dx_q <= get_digit(VEC_MAX_W'(a_q), 32'(nxt_idx));
                  dy_q <= get_digit(VEC_MAX_W'(b_q), 32'(nxt_idx));
                  dc_q <= dco_in;
               end
            end
            DONE: begin
               done_q <= 1'b0;
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               done_q <= 1'b0;
               busy_q <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   assign busy_out = busy_q;
   assign done_out = done_q;
   assign err_out  = err_q;
   assign sum_out  = sum_q;
   assign cout_out = cout_q;
   assign dx_out   = dx_q;
   assign dy_out   = dy_q;
   assign dc_out   = dc_q;

endmodule

// File: tb/tb_bcd_serial_sum_ctrl.sv
// tb/tb_bcd_serial_sum_ctrl.sv - self-checking bench for the digit-serial BCD adder sequencer
module tb_bcd_serial_sum_ctrl;

   localparam int DIGITS = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   logic        cin;
   logic        busy;
   logic        done;
   logic        err;
   logic [15:0] sum;
   logic        cout;
   logic [3:0]  dx;
   logic [3:0]  dy;
   logic        dc;
   logic [3:0]  dz;
   logic        dco;
   logic [4:0]  dsum;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic [15:0] sum;
      logic        cout;
      logic        err;
      logic [3:0]  dcs;
   } vec_t;

   vec_t tbl[7];

   always #5 clk = ~clk;

   bcd_serial_sum_ctrl #(.DIGITS(DIGITS)) dut (
      .clk_in   (clk),
      .rst_n_in (rst_n),
      .start_in (start),
      .a_in     (a),
      .b_in     (b),
      .cin_in   (cin),
      .busy_out (busy),
      .done_out (done),
      .err_out  (err),
      .sum_out  (sum),
      .cout_out (cout),
      .dx_out   (dx),
      .dy_out   (dy),
      .dc_out   (dc),
      .dz_in    (dz),
      .dco_in   (dco)
   );

   // Behavioural one-digit BCD adder
   always_comb begin
      dsum = 5'(dx) + 5'(dy) + 5'(dc);
      dz   = dsum[3:0];
      dco  = 1'b0;
      if (dsum > 5'd9) begin
         dz  = 4'(dsum - 5'd10);
         dco = 1'b1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: whole-number decimal arithmetic on the operands
   function automatic void ref_model(input logic [15:0] ra, input logic [15:0] rb, input logic rc,
                                     output logic [15:0] rs, output logic rco, output logic rer,
                                     output logic [3:0] rdcs);
      int av, bv, tot, p;
      rer  = 1'b0;
      rs   = '0;
      rco  = 1'b0;
      rdcs = '0;
      for (int i = 0; i < 4; i++)
         if (ra[i*4 +: 4] > 4'd9 || rb[i*4 +: 4] > 4'd9) rer = 1'b1;
      if (!rer) begin
         av = 0;
         bv = 0;
         for (int i = 3; i >= 0; i--) begin
            av = av * 10 + int'(ra[i*4 +: 4]);
            bv = bv * 10 + int'(rb[i*4 +: 4]);
         end
         tot = av + bv + int'(rc);
         rco = (tot >= 10000);
         tot = tot % 10000;
         for (int i = 0; i < 4; i++) begin
            rs[i*4 +: 4] = 4'(tot % 10);
            tot = tot / 10;
         end
         p = 1;
         for (int i = 0; i < 4; i++) begin
            rdcs[i] = ((av % p) + (bv % p) + int'(rc)) >= p;
            p = p * 10;
         end
      end
   endfunction

   // One complete operation from an IDLE cycle, with operands scrambled after acceptance
   task automatic run_op(input string nm, input logic [15:0] ra, input logic [15:0] rb,
                         input logic rc, input logic [15:0] es, input logic ec,
                         input logic ee, input logic [3:0] edc);
      int          cyc;
      logic        got;
      logic        busy_ok;
      logic [3:0]  dcs;
      logic [15:0] dxt;
      logic [15:0] dyt;
      a     = ra;
      b     = rb;
      cin   = rc;
      start = 1'b1;
      tick();
      start   = 1'b0;
      a       = 16'($urandom);
      b       = 16'($urandom);
      cin     = 1'($urandom);
      cyc     = 1;
      got     = 1'b0;
      busy_ok = 1'b1;
      dcs     = '0;
      dxt     = '0;
      dyt     = '0;
      while (!got && cyc <= 20) begin
         if (done) begin
            got = 1'b1;
         end else begin
            if (!busy) busy_ok = 1'b0;
            if (cyc <= 4) begin
               dcs[cyc-1]         = dc;
               dxt[(cyc-1)*4 +: 4] = dx;
               dyt[(cyc-1)*4 +: 4] = dy;
            end
            tick();
            cyc++;
         end
      end
      check({nm, "_done_seen"}, 32'(got), 32'd1);
      check({nm, "_latency"}, 32'(cyc), ee ? 32'd1 : 32'(DIGITS + 1));
      check({nm, "_busy"}, 32'({busy_ok, busy}), 32'b11);
      check({nm, "_sum"}, 32'(sum), 32'(es));
      check({nm, "_cout"}, 32'(cout), 32'(ec));
      check({nm, "_err"}, 32'(err), 32'(ee));
      check({nm, "_dc_trace"}, 32'(dcs), 32'(edc));
      check({nm, "_dx_trace"}, 32'(dxt), ee ? 32'd0 : 32'(ra));
      check({nm, "_dy_trace"}, 32'(dyt), ee ? 32'd0 : 32'(rb));
      check({nm, "_ports_idle"}, 32'({dx, dy, dc}), 32'd0);
      tick();
      check({nm, "_post_done"}, 32'({done, busy, err, cout, sum}), 32'({2'b00, ee, ec, es}));
   endtask

   initial begin
      logic [15:0] ra, rb, es;
      logic        rc, ec, ee;
      logic [3:0]  edc;
      logic        done_seen;
      int          cyc;

      tbl[0] = '{16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 4'b0110};
      tbl[1] = '{16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 4'b1110};
      tbl[2] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 4'b0001};
      tbl[3] = '{16'h12A4, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 4'b0000};
      tbl[4] = '{16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0, 4'b1111};
      tbl[5] = '{16'h0500, 16'h0500, 1'b0, 16'h1000, 1'b0, 1'b0, 4'b1000};
      tbl[6] = '{16'h0000, 16'hF000, 1'b1, 16'h0000, 1'b0, 1'b1, 4'b0000};

      rst_n = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;
      cin   = 1'b0;
      tick();
      tick();
      check("reset_outputs", 32'({busy, done, err, cout, sum, dx, dy, dc}), 32'd0);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 7; i++)
         run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].cin,
                tbl[i].sum, tbl[i].cout, tbl[i].err, tbl[i].dcs);

      // Start while busy is ignored; start held through DONE is taken in the following IDLE cycle
      a     = 16'h1234;
      b     = 16'h5678;
      cin   = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      a     = 16'h1111;
      b     = 16'h1111;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      check("ignore_done_c5", 32'({done, busy, sum}), 32'({2'b11, 16'h6912}));
      a     = 16'h0005;
      b     = 16'h0004;
      start = 1'b1;
      tick();
      check("hold_idle_c6", 32'({done, busy, sum}), 32'({2'b00, 16'h6912}));
      tick();
      check("hold_accept_c7", 32'(busy), 32'd1);
      start = 1'b0;
      cyc   = 7;
      while (!done && cyc < 30) begin
         tick();
         cyc++;
      end
      check("hold_latency", 32'(cyc), 32'd11);
      check("hold_sum", 32'({cout, err, sum}), 32'({2'b00, 16'h0009}));
      tick();

      // Reset in cycle 3 of a run aborts it
      a     = 16'h1234;
      b     = 16'h5678;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      check("abort_outputs", 32'({busy, done, err, cout, sum, dx, dy, dc}), 32'd0);
      done_seen = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         done_seen |= done;
      end
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         done_seen |= done;
      end
      check("abort_no_done", 32'({done_seen, busy}), 32'd0);
      run_op("after_abort", 16'h0500, 16'h0500, 1'b0, 16'h1000, 1'b0, 1'b0, 4'b1000);

      // Randomised operations against the decimal reference
      for (int n = 0; n < 40; n++) begin
         for (int d = 0; d < 4; d++) begin
            if ($urandom_range(0, 15) < 14) ra[d*4 +: 4] = 4'($urandom_range(0, 9));
            else                            ra[d*4 +: 4] = 4'($urandom_range(10, 15));
            if ($urandom_range(0, 15) < 14) rb[d*4 +: 4] = 4'($urandom_range(0, 9));
            else                            rb[d*4 +: 4] = 4'($urandom_range(10, 15));
         end
         rc = 1'($urandom);
         ref_model(ra, rb, rc, es, ec, ee, edc);
         run_op($sformatf("rnd%0d", n), ra, rb, rc, es, ec, ee, edc);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
